// File: rtl/ibex_pkg.sv
// Shared types for the EX-stage arbiter: ALU operators, arbiter FSM states and datapath owners.
package ibex_pkg;

    typedef enum logic [6:0] {
        ALU_ADD = 7'd0,
        ALU_SUB = 7'd1,
        ALU_XOR = 7'd2,
        ALU_OR  = 7'd3,
        ALU_AND = 7'd4,
        ALU_SRA = 7'd5,
        ALU_SRL = 7'd6,
        ALU_SLL = 7'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ArbIdle     = 2'd0,
        ArbBusyCore = 2'd1,
        ArbBusyBloc = 2'd2
    } ex_arb_state_e;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerCore = 2'd1,
        OwnerBloc = 2'd2
    } ex_owner_e;

endpackage

// File: rtl/ibex_ex_arb_prio.sv
// Winner select for the shared EX datapath: core priority with a starvation guard that
// forces a BLOC grant after MaxStarve consecutive core grants while BLOC is waiting.
module ibex_ex_arb_prio
    import ibex_pkg::*;
#(
    parameter int unsigned MaxStarve = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      idle_i,
    input  logic      core_req_i,
    input  logic      bloc_req_i,
    output ex_owner_e winner_o
);

    localparam int unsigned CntW = $clog2(MaxStarve + 1);

    logic [CntW-1:0] starve_q, starve_d;
    logic            bloc_force;

    assign bloc_force = bloc_req_i && (starve_q == CntW'(MaxStarve));

    always_comb begin
        winner_o = OwnerNone;
        if (idle_i) begin
            if (bloc_force) begin
                winner_o = OwnerBloc;
            end else if (core_req_i) begin
                winner_o = OwnerCore;
            end else if (bloc_req_i) begin
                winner_o = OwnerBloc;
            end
        end
    end

    // Counts core wins over a waiting BLOC; any gap in bloc_req_i restarts the count.
    always_comb begin
        starve_d = starve_q;
        if (!bloc_req_i || winner_o == OwnerBloc) begin
            starve_d = '0;
        end else if (winner_o == OwnerCore && starve_q != CntW'(MaxStarve)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ibex_ex_arbiter.sv
// Shares the EX ALU/BLOC datapath between the core issue path and the BLOC scan engine:
// grants in IDLE, registers the winner's operands, holds ownership until ex_valid_i.
module ibex_ex_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxStarve = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  alu_op_e     core_op_i,
    input  logic [31:0] core_opa_i,
    input  logic [31:0] core_opb_i,
    input  logic        core_flush_i,
    output logic        core_rsp_valid_o,
    output logic [31:0] core_rsp_data_o,

    input  logic        bloc_req_i,
    output logic        bloc_gnt_o,
    input  logic [31:0] bloc_opa_i,
    input  logic [31:0] bloc_mask_i,
    input  logic [31:0] bloc_set_i,
    output logic        bloc_rsp_valid_o,
    output logic [31:0] bloc_rsp_data_o,

    output alu_op_e     ex_alu_operator_o,
    output logic [31:0] ex_operand_a_o,
    output logic [31:0] ex_operand_b_o,
    output logic        ex_first_cycle_o,
    output logic        ex_bloc_op_o,
    output logic [31:0] ex_bloc_mask_o,
    output logic [31:0] ex_bloc_set_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] ex_bloc_result_i
);

    ex_arb_state_e state_q, state_d;
    ex_owner_e     winner;
    logic          core_req_eff;

    alu_op_e       op_q;
    logic [31:0]   opa_q, opb_q, mask_q, set_q;
    logic          first_q;

    logic          core_rsp_valid_q, core_rsp_valid_d;
    logic          bloc_rsp_valid_q, bloc_rsp_valid_d;
    logic [31:0]   core_rsp_data_q, bloc_rsp_data_q;

    assign core_req_eff = core_req_i && !core_flush_i;

    ibex_ex_arb_prio #(
        .MaxStarve(MaxStarve)
    ) u_prio (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idle_i     (state_q == ArbIdle),
        .core_req_i (core_req_eff),
        .bloc_req_i (bloc_req_i),
        .winner_o   (winner)
    );

    assign core_gnt_o = (winner == OwnerCore);
    assign bloc_gnt_o = (winner == OwnerBloc);

    always_comb begin
        state_d          = state_q;
        core_rsp_valid_d = 1'b0;
        bloc_rsp_valid_d = 1'b0;
        unique case (state_q)
            ArbIdle: begin
                if (winner == OwnerCore) begin
                    state_d = ArbBusyCore;
                end else if (winner == OwnerBloc) begin
                    state_d = ArbBusyBloc;
                end
            end
            ArbBusyCore: begin
                // Flush wins over a coincident ex_valid_i: the result is discarded.
                if (core_flush_i) begin
                    state_d = ArbIdle;
                end else if (ex_valid_i) begin
                    state_d          = ArbIdle;
                    core_rsp_valid_d = 1'b1;
                end
            end
            ArbBusyBloc: begin
                if (ex_valid_i) begin
                    state_d          = ArbIdle;
                    bloc_rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ArbIdle;
            op_q             <= ALU_ADD;
            opa_q            <= '0;
            opb_q            <= '0;
            mask_q           <= '0;
            set_q            <= '0;
            first_q          <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            bloc_rsp_valid_q <= 1'b0;
            core_rsp_data_q  <= '0;
            bloc_rsp_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            first_q          <= core_gnt_o || bloc_gnt_o;
            core_rsp_valid_q <= core_rsp_valid_d;
            bloc_rsp_valid_q <= bloc_rsp_valid_d;
            if (core_gnt_o) begin
                op_q   <= core_op_i;
                opa_q  <= core_opa_i;
                opb_q  <= core_opb_i;
                mask_q <= '0;
                set_q  <= '0;
            end else if (bloc_gnt_o) begin
                op_q   <= ALU_ADD;
                opa_q  <= bloc_opa_i;
                opb_q  <= '0;
                mask_q <= bloc_mask_i;
                set_q  <= bloc_set_i;
            end
            if (core_rsp_valid_d) begin
                core_rsp_data_q <= ex_result_i;
            end
            if (bloc_rsp_valid_d) begin
                bloc_rsp_data_q <= ex_bloc_result_i;
            end
        end
    end

    assign ex_alu_operator_o = op_q;
    assign ex_operand_a_o    = opa_q;
    assign ex_operand_b_o    = opb_q;
    assign ex_bloc_mask_o    = mask_q;
    assign ex_bloc_set_o     = set_q;
    assign ex_first_cycle_o  = first_q;
    assign ex_bloc_op_o      = (state_q == ArbBusyBloc);

    assign core_rsp_valid_o  = core_rsp_valid_q;
    assign core_rsp_data_o   = core_rsp_data_q;
    assign bloc_rsp_valid_o  = bloc_rsp_valid_q;
    assign bloc_rsp_data_o   = bloc_rsp_data_q;

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({core_gnt_o, bloc_gnt_o}));
    a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({core_rsp_valid_o, bloc_rsp_valid_o}));
    a_gnt_only_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (core_gnt_o || bloc_gnt_o) |-> (state_q == ArbIdle));
    a_first_after_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
        ex_first_cycle_o |-> $past(core_gnt_o || bloc_gnt_o));

endmodule

// File: tb/tb_ibex_ex_arbiter.sv
// Randomized scoreboard bench for ibex_ex_arbiter; the bench itself plays the EX block.
module tb_ibex_ex_arbiter;
    import ibex_pkg::*;

    localparam int MaxStarve = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0, core_flush_i = 1'b0, bloc_req_i = 1'b0;
    alu_op_e     core_op_i = ALU_ADD;
    logic [31:0] core_opa_i = '0, core_opb_i = '0;
    logic [31:0] bloc_opa_i = '0, bloc_mask_i = '0, bloc_set_i = '0;
    logic        ex_valid_i = 1'b0;
    logic [31:0] ex_result_i = '0, ex_bloc_result_i = '0;
    logic        core_gnt_o, bloc_gnt_o, core_rsp_valid_o, bloc_rsp_valid_o;
    logic [31:0] core_rsp_data_o, bloc_rsp_data_o;
    alu_op_e     ex_alu_operator_o;
    logic [31:0] ex_operand_a_o, ex_operand_b_o, ex_bloc_mask_o, ex_bloc_set_o;
    logic        ex_first_cycle_o, ex_bloc_op_o;

    ibex_ex_arbiter #(.MaxStarve(MaxStarve)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_op_i(core_op_i),
        .core_opa_i(core_opa_i), .core_opb_i(core_opb_i), .core_flush_i(core_flush_i),
        .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_data_o(core_rsp_data_o),
        .bloc_req_i(bloc_req_i), .bloc_gnt_o(bloc_gnt_o), .bloc_opa_i(bloc_opa_i),
        .bloc_mask_i(bloc_mask_i), .bloc_set_i(bloc_set_i),
        .bloc_rsp_valid_o(bloc_rsp_valid_o), .bloc_rsp_data_o(bloc_rsp_data_o),
        .ex_alu_operator_o(ex_alu_operator_o), .ex_operand_a_o(ex_operand_a_o),
        .ex_operand_b_o(ex_operand_b_o), .ex_first_cycle_o(ex_first_cycle_o),
        .ex_bloc_op_o(ex_bloc_op_o), .ex_bloc_mask_o(ex_bloc_mask_o),
        .ex_bloc_set_o(ex_bloc_set_o), .ex_valid_i(ex_valid_i),
        .ex_result_i(ex_result_i), .ex_bloc_result_i(ex_bloc_result_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_bloc;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    // Stimulus intent for the next cycle
    bit          d_creq, d_flush, d_breq;
    alu_op_e     d_op;
    logic [31:0] d_a, d_b, d_ba, d_mask, d_set;
    int          d_lat;

    // Reference model: who owns EX, cycles left, latched operands, starvation count
    int          m_owner, m_rem, m_starve, m_last_gnt, dut_gnt;
    bit          m_first;
    alu_op_e     m_op;
    logic [31:0] m_a, m_b, m_mask, m_set, last_core, last_bloc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] bloc_fn(input logic [31:0] a, input logic [31:0] mask, input logic [31:0] set);
        return (a & ~mask) | (set & mask);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_rem = 0; m_starve = 0; m_first = 0; m_last_gnt = 0;
        m_op = ALU_ADD; m_a = '0; m_b = '0; m_mask = '0; m_set = '0;
        last_core = '0; last_bloc = '0;
        exp_q.delete();
    endtask

    // One clock: drive at posedge+1, compare at posedge+3, advance the model, wait next edge.
    task automatic do_cycle();
        bit creq_eff;
        int exp_gnt;
        core_req_i = d_creq; core_flush_i = d_flush; bloc_req_i = d_breq;
        core_op_i = d_op; core_opa_i = d_a; core_opb_i = d_b;
        bloc_opa_i = d_ba; bloc_mask_i = d_mask; bloc_set_i = d_set;
        ex_valid_i = (m_owner != 0) && (m_rem == 1);
        ex_result_i = alu(m_op, m_a, m_b);
        ex_bloc_result_i = bloc_fn(m_a, m_mask, m_set);
        #2;
        exp_gnt = 0;
        if (m_owner == 0) begin
            creq_eff = d_creq && !d_flush;
            if (d_breq && m_starve == MaxStarve) exp_gnt = 2;
            else if (creq_eff) exp_gnt = 1;
            else if (d_breq) exp_gnt = 2;
        end
        check32("core_gnt", core_gnt_o, exp_gnt == 1);
        check32("bloc_gnt", bloc_gnt_o, exp_gnt == 2);
        check32("ex_first_cycle", ex_first_cycle_o, m_first);
        check32("ex_bloc_op", ex_bloc_op_o, m_owner == 2);
        check32("ex_operator", 32'(ex_alu_operator_o), 32'(m_op));
        check32("ex_operand_a", ex_operand_a_o, m_a);
        check32("ex_operand_b", ex_operand_b_o, m_b);
        check32("ex_bloc_mask", ex_bloc_mask_o, m_mask);
        check32("ex_bloc_set", ex_bloc_set_o, m_set);
        dut_gnt = core_gnt_o ? 1 : (bloc_gnt_o ? 2 : 0);

        if (m_owner == 1 && d_flush) begin
            m_owner = 0;
        end else if (m_owner != 0 && m_rem == 1) begin
            exp_q.push_back('{is_bloc: (m_owner == 2),
                              data: (m_owner == 2) ? bloc_fn(m_a, m_mask, m_set) : alu(m_op, m_a, m_b),
                              due: cyc + 1});
            m_owner = 0;
        end else if (m_owner != 0) begin
            m_rem--;
        end
        m_first = 0;
        if (exp_gnt == 1) begin
            m_owner = 1; m_rem = d_lat; m_first = 1;
            m_op = d_op; m_a = d_a; m_b = d_b; m_mask = '0; m_set = '0;
        end else if (exp_gnt == 2) begin
            m_owner = 2; m_rem = d_lat; m_first = 1;
            m_op = ALU_ADD; m_a = d_ba; m_b = '0; m_mask = d_mask; m_set = d_set;
        end
        if (!d_breq || exp_gnt == 2) m_starve = 0;
        else if (exp_gnt == 1 && m_starve < MaxStarve) m_starve++;
        m_last_gnt = exp_gnt;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset one tick after an edge and checks every output is cleared asynchronously.
    task automatic apply_reset();
        rst_i = 1'b1;
        #2;
        check32("rst_core_gnt", core_gnt_o, 0);
        check32("rst_bloc_gnt", bloc_gnt_o, 0);
        check32("rst_core_rsp_valid", core_rsp_valid_o, 0);
        check32("rst_bloc_rsp_valid", bloc_rsp_valid_o, 0);
        check32("rst_core_rsp_data", core_rsp_data_o, 0);
        check32("rst_bloc_rsp_data", bloc_rsp_data_o, 0);
        check32("rst_ex_operator", 32'(ex_alu_operator_o), 0);
        check32("rst_ex_operand_a", ex_operand_a_o, 0);
        check32("rst_ex_operand_b", ex_operand_b_o, 0);
        check32("rst_ex_first", ex_first_cycle_o, 0);
        check32("rst_ex_bloc_op", ex_bloc_op_o, 0);
        check32("rst_ex_mask_set", ex_bloc_mask_o | ex_bloc_set_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic quiet(input int n);
        d_creq = 0; d_breq = 0; d_flush = 0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    // Both requesters held with single-cycle ops: grants must follow C,C,C,C,B repeating.
    task automatic run_pattern(input int ngr);
        int exp_pat[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        int seen = 0;
        for (int i = 0; i < 3 * ngr && seen < ngr; i++) begin
            d_creq = 1; d_breq = 1; d_flush = 0; d_lat = 1;
            d_op = alu_op_e'($urandom_range(0, 4)); d_a = $urandom; d_b = $urandom;
            d_ba = $urandom; d_mask = $urandom; d_set = $urandom;
            do_cycle();
            if (dut_gnt != 0) begin
                check32("grant_pattern", dut_gnt, exp_pat[seen]);
                seen++;
            end
        end
        check32("grant_pattern_count", seen, ngr);
        quiet(3);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (core_rsp_valid_o || bloc_rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected @cyc %0d: actual core=%0b bloc=%0b required none",
                             cyc, core_rsp_valid_o, bloc_rsp_valid_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("rsp_due_cycle", cyc, mon_e.due);
                    check32("rsp_core_valid", core_rsp_valid_o, !mon_e.is_bloc);
                    check32("rsp_bloc_valid", bloc_rsp_valid_o, mon_e.is_bloc);
                    if (mon_e.is_bloc) last_bloc = mon_e.data;
                    else last_core = mon_e.data;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL rsp_missing @cyc %0d: actual no pulse required %s rsp data %h",
                         cyc, mon_e.is_bloc ? "bloc" : "core", mon_e.data);
            end
            check32("core_rsp_data", core_rsp_data_o, last_core);
            check32("bloc_rsp_data", bloc_rsp_data_o, last_bloc);
        end
    end

    int bloc_cycles, bloc_rsps;

    initial begin
        d_creq = 0; d_flush = 0; d_breq = 0; d_op = ALU_ADD;
        d_a = '0; d_b = '0; d_ba = '0; d_mask = '0; d_set = '0; d_lat = 1;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Core ADD 5+7, single-cycle EX: grant T, first T+1, response 12 at T+2
        d_creq = 1; d_op = ALU_ADD; d_a = 32'd5; d_b = 32'd7; d_lat = 1;
        do_cycle();
        check32("add_core_gnt_T", dut_gnt, 1);
        d_creq = 0;
        check32("add_first_T1", ex_first_cycle_o, 1);
        do_cycle();
        check32("add_rsp_valid_T2", core_rsp_valid_o, 1);
        check32("add_rsp_data_T2", core_rsp_data_o, 32'd12);
        quiet(2);

        run_pattern(10);

        // BLOC op, 3-cycle EX
        d_breq = 1; d_ba = 32'h1234_5678; d_mask = 32'h0000_00FF; d_set = 32'h0000_00A5; d_lat = 3;
        do_cycle();
        d_breq = 0;
        bloc_cycles = 0; bloc_rsps = 0;
        for (int i = 0; i < 5; i++) begin
            bloc_cycles += int'(ex_bloc_op_o);
            bloc_rsps += int'(bloc_rsp_valid_o);
            if (bloc_rsp_valid_o) check32("bloc_rsp_value", bloc_rsp_data_o, 32'h1234_56A5);
            do_cycle();
        end
        check32("bloc_op_cycles", bloc_cycles, 3);
        check32("bloc_rsp_pulses", bloc_rsps, 1);
        quiet(2);

        // Flush coincident with ex_valid in BUSY_CORE; waiting BLOC granted next cycle
        d_creq = 1; d_breq = 1; d_op = ALU_SUB; d_a = $urandom; d_b = $urandom; d_lat = 2;
        d_ba = $urandom; d_mask = $urandom; d_set = $urandom;
        do_cycle();
        check32("flush_core_gnt", dut_gnt, 1);
        d_creq = 0; d_lat = 1;
        do_cycle();
        d_flush = 1;
        do_cycle();
        d_flush = 0;
        check32("flush_no_core_rsp", core_rsp_valid_o, 0);
        do_cycle();
        check32("flush_bloc_gnt_next", dut_gnt, 2);
        quiet(3);

        // Reset while BUSY_BLOC, before ex_valid
        d_breq = 1; d_ba = $urandom; d_mask = $urandom; d_set = $urandom; d_lat = 3;
        do_cycle();
        d_breq = 0;
        do_cycle();
        apply_reset();
        quiet(3);
        run_pattern(5);

        // Flush in IDLE masks core; BLOC granted, core never granted
        d_creq = 1; d_flush = 1; d_breq = 1; d_lat = 1;
        d_ba = $urandom; d_mask = $urandom; d_set = $urandom;
        do_cycle();
        check32("idle_flush_bloc_gnt", dut_gnt, 2);
        d_breq = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            check32("idle_flush_no_core_gnt", dut_gnt == 1, 0);
        end
        quiet(3);

        // Randomized traffic with requesters that hold until granted or flushed
        d_creq = 0; d_breq = 0; d_flush = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_last_gnt == 1 || d_flush) d_creq = 0;
            if (m_last_gnt == 2) d_breq = 0;
            if (!d_creq && $urandom_range(0, 1) == 1) begin
                d_creq = 1; d_op = alu_op_e'($urandom_range(0, 4));
                d_a = $urandom; d_b = $urandom;
            end
            if (!d_breq && $urandom_range(0, 2) == 0) begin
                d_breq = 1; d_ba = $urandom; d_mask = $urandom; d_set = $urandom;
            end
            d_flush = ($urandom_range(0, 9) == 0);
            d_lat = $urandom_range(1, 3);
            do_cycle();
        end
        quiet(6);
        check32("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
